mux_nx_pipe: RTL and testbench
==============================

// Module: mux_nx_pipe
// PURPOSE
//   Parametrised N-input, WIDTH-bit select mux with registered output and valid/ready handshake.
//   Successor to the combinational 2x32 datapath muxes; used where a CPU source select
//   (writeback/forwarding/bus source) must cross a pipeline boundary under backpressure.
//   Two-entry output buffer (main + skid) keeps in_ready registered, never combinational from out_ready.
// PARAMETERS
//   WIDTH  32  data width per input
//   NIN    4   number of inputs (>=2, need not be a power of two)
//   SELW   2   select width, must equal max(1,$clog2(NIN))
//   CNTW   16  width of transfer counter
// PORTS
//   clk       in   1          rising-edge clock
//   clrn      in   1          asynchronous active-low reset
//   sel       in   SELW       input select; upstream holds it registered
//   in_data   in   NIN*WIDTH  input i at bits [i*WIDTH +: WIDTH]
//   in_valid  in   NIN        per-input valid
//   in_ready  out  NIN        per-input ready; only in_ready[sel] may be 1
//   out_data  out  WIDTH      registered output data
//   out_valid out  1          output valid
//   out_ready in   1          downstream ready
//   sel_err   out  1          registered: illegal sel seen with any in_valid last cycle
//   xfer_cnt  out  CNTW       count of accepted input transfers, wraps
// BEHAVIOUR
//   - Reset (clrn=0, async): state=EMPTY, out_valid=0, out_data=0, skid=0, sel_err=0,
//     xfer_cnt=0, in_ready=0 while clrn low; rdy_r=1 from first edge after release.
//   - rdy_r registered = (state != TWO). sel_ok = (sel < NIN).
//     in_ready[i] = rdy_r & sel_ok & (sel==i); all other bits 0.
//   - acc = in_valid[sel] & in_ready[sel]; pop = out_valid & out_ready.
//   - States (out_valid = state!=EMPTY):
//     EMPTY: acc -> ONE, main<=in_data[sel]; else stay.
//     ONE:   acc&pop -> ONE, main<=new; acc&!pop -> TWO, skid<=new;
//            !acc&pop -> EMPTY; else stay (main held).
//     TWO:   no accept (rdy_r=0); pop -> ONE, main<=skid; else stay, both held.
//   - Latency: data accepted at edge k appears on out_data after edge k (1 cycle) when buffer empty.
//   - Order: strict FIFO across main/skid; no data loss or duplication under any out_ready pattern.
//   - out_data holds its last value when out_valid=0 (not cleared on pop).
//   - sel change mid-stream is legal; affects only the next accept, never buffered data.
//   - sel >= NIN: no input accepted; sel_err<=1 next cycle if any in_valid, else 0.
//   - xfer_cnt += 1 on every acc; wraps 2^CNTW-1 -> 0 silently.
//   - Reset mid-operation: buffered data discarded, all outputs to reset values immediately.
//   - No combinational path out_ready -> in_ready; paths sel -> in_ready allowed.
// TESTING
//   1 Reset: clrn=0 with in_valid=all 1 -> in_ready=0, out_valid=0, out_data=0, xfer_cnt=0.
//   2 Basic: in0=0xFFFFFFFF, in1=0x00000000, out_ready=1; sel=0 one beat -> out_data=0xFFFFFFFF
//     next cycle; sel=1 -> 0x00000000; repeat with 0x55555555/0xAAAAAAAA; xfer_cnt=4.
//   3 Backpressure: out_ready=0, push 0x11,0x22,0x33 on sel=2 -> 2 accepted, in_ready[2]=0
//     after 2nd; out_ready=1 -> outputs 0x11,0x22 then 0x33, order kept, xfer_cnt=3.
//   4 Illegal sel: NIN=3, sel=3, in_valid=3'b111 -> in_ready=0, sel_err=1 next cycle, no transfer.
//   5 Reset mid-op: buffer in TWO, pulse clrn low -> out_valid=0 at once; 1st push after release
//     is first output.
//   6 Wrap: CNTW=4, 17 accepts with random out_ready -> xfer_cnt=1; scoreboard vs reference model.

Source files
------------

// File: rtl/mux_nx_pipe.sv
// N-input, WIDTH-bit select mux with a registered two-entry (main + skid) output buffer.
// in_ready comes from a flop, so out_ready never reaches in_ready combinationally.
module mux_nx_pipe #(
  parameter int WIDTH = 32,
  parameter int NIN   = 4,
  parameter int SELW  = 2,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [SELW-1:0]       sel,
  input  logic [NIN*WIDTH-1:0]  in_data,
  input  logic [NIN-1:0]        in_valid,
  output logic [NIN-1:0]        in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic [CNTW-1:0]       xfer_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  logic             rdy_r;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic             sel_ok;
  logic             acc;
  logic             pop;

  assign sel_ok = (int'(sel) < NIN);

  // An out-of-range sel matches no input, so the loop never indexes past in_data.
  // NOTE: every output gets a default before the loop, otherwise unmatched sel values infer latches.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < NIN; i++) begin
      if (sel == SELW'(i)) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        sel_valid   = in_valid[i];
        in_ready[i] = rdy_r;
      end
    end
  end

  assign acc      = sel_valid & rdy_r & sel_ok;
  assign pop      = out_valid & out_ready;
  assign out_data = main_q;

  // rdy_r is updated alongside state so it always equals (state != TWO) after the first edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= EMPTY;
      rdy_r     <= 1'b0;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          rdy_r <= 1'b1;
          if (acc) begin
            state     <= ONE;
            out_valid <= 1'b1;
            main_q    <= sel_data;
          end
        end
        ONE: begin
          rdy_r <= 1'b1;
          if (acc && pop) begin
            main_q <= sel_data;
          end else if (acc) begin
            state  <= TWO;
            rdy_r  <= 1'b0;
            skid_q <= sel_data;
          end else if (pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            state  <= ONE;
            rdy_r  <= 1'b1;
            main_q <= skid_q;
          end
        end
        default: begin
          state     <= EMPTY;
          rdy_r     <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sel_err  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      sel_err <= ~sel_ok & (|in_valid);
      if (acc) xfer_cnt <= xfer_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_mux_nx_pipe.sv
// Directed bench for mux_nx_pipe (NIN=3, CNTW=4): reset, basic select, backpressure,
// illegal sel, reset mid-operation and counter wrap against a queue reference model.
module tb_mux_nx_pipe;

  localparam int WIDTH = 32;
  localparam int NIN   = 3;
  localparam int SELW  = 2;
  localparam int CNTW  = 4;

  logic                 clk = 1'b0;
  logic                 clrn;
  logic [SELW-1:0]      sel;
  logic [NIN*WIDTH-1:0] in_data;
  logic [NIN-1:0]       in_valid;
  logic [NIN-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sel_err;
  logic [CNTW-1:0]      xfer_cnt;

  logic [WIDTH-1:0] in_word [NIN];
  assign in_data = {in_word[2], in_word[1], in_word[0]};

  int checks = 0;
  int errors = 0;

  mux_nx_pipe #(.WIDTH(WIDTH), .NIN(NIN), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Present one beat on input s, let one edge take it, then drop valid.
  task automatic beat(input logic [SELW-1:0] s, input logic [WIDTH-1:0] d);
    sel        = s;
    in_word[s] = d;
    in_valid   = NIN'(1) << s;
    tick();
    in_valid   = '0;
    settle();
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
    tick();
    settle();
  endtask

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] d;
  logic [NIN-1:0]   exp_rdy;
  int               n_acc;
  int               budget;

  initial begin
    // 1: reset with every input valid
    clrn = 1'b0; sel = '0; in_valid = '1; out_ready = 1'b0;
    for (int i = 0; i < NIN; i++) in_word[i] = 32'hDEAD_0000 + i;
    tick(); tick();
    check("rst_in_ready",  in_ready,  3'b000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  32'h0);
    check("rst_xfer_cnt",  xfer_cnt,  4'd0);
    check("rst_sel_err",   sel_err,   1'b0);
    in_valid = '0;
    clrn = 1'b1;
    tick(); settle();
    check("rel_in_ready", in_ready, 3'b001);

    // 2: basic select, one-cycle latency
    out_ready = 1'b1;
    in_word[0] = 32'hFFFF_FFFF; in_word[1] = 32'h0000_0000;
    beat(2'd0, 32'hFFFF_FFFF);
    check("basic0_data",  out_data,  32'hFFFF_FFFF);
    check("basic0_valid", out_valid, 1'b1);
    beat(2'd1, 32'h0000_0000);
    check("basic1_data",  out_data,  32'h0000_0000);
    beat(2'd0, 32'h5555_5555);
    check("basic2_data",  out_data,  32'h5555_5555);
    beat(2'd1, 32'hAAAA_AAAA);
    check("basic3_data",  out_data,  32'hAAAA_AAAA);
    tick();
    check("basic_drain_valid", out_valid, 1'b0);
    check("basic_hold_data",   out_data,  32'hAAAA_AAAA);
    check("basic_xfer_cnt",    xfer_cnt,  4'd4);

    // 3: backpressure fills main then skid
    do_reset();
    out_ready = 1'b0; sel = 2'd2; in_word[2] = 32'h11; in_valid = 3'b100;
    settle();
    check("bp_ready0", in_ready, 3'b100);
    tick();
    in_word[2] = 32'h22; settle();
    check("bp_ready1", in_ready, 3'b100);
    tick();
    in_word[2] = 32'h33; settle();
    check("bp_ready_full", in_ready, 3'b000);
    check("bp_head",       out_data, 32'h11);
    tick();
    check("bp_cnt_held", xfer_cnt, 4'd2);
    check("bp_head_held", out_data, 32'h11);
    out_ready = 1'b1; settle();
    check("bp_ready_still0", in_ready, 3'b000);
    tick();
    check("bp_second",   out_data,  32'h22);
    check("bp_valid",    out_valid, 1'b1);
    check("bp_ready_rt", in_ready,  3'b100);
    tick();
    in_valid = '0; settle();
    check("bp_third", out_data, 32'h33);
    check("bp_cnt",   xfer_cnt, 4'd3);
    tick();
    check("bp_empty", out_valid, 1'b0);

    // 4: illegal sel
    sel = 2'd3; in_valid = 3'b111; settle();
    check("ill_in_ready", in_ready, 3'b000);
    tick();
    check("ill_sel_err", sel_err,   1'b1);
    check("ill_cnt",     xfer_cnt,  4'd3);
    check("ill_valid",   out_valid, 1'b0);
    in_valid = '0;
    tick();
    check("ill_sel_err_clr", sel_err, 1'b0);

    // 5: reset while the buffer is full
    do_reset();
    out_ready = 1'b0; sel = 2'd0; in_word[0] = 32'hA1; in_valid = 3'b001;
    tick();
    in_word[0] = 32'hA2;
    tick();
    in_valid = '0; settle();
    check("mid_full_valid", out_valid, 1'b1);
    check("mid_full_ready", in_ready,  3'b000);
    clrn = 1'b0; settle();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data",  out_data,  32'h0);
    check("mid_rst_cnt",   xfer_cnt,  4'd0);
    tick();
    clrn = 1'b1;
    tick();
    out_ready = 1'b1;
    beat(2'd0, 32'hB1);
    check("mid_first_out", out_data,  32'hB1);
    check("mid_first_vld", out_valid, 1'b1);

    // 6: counter wrap, random traffic against a queue model
    do_reset();
    q.delete();
    n_acc  = 0;
    budget = 0;
    while (n_acc < 17 && budget < 400) begin
      budget++;
      sel       = SELW'($urandom_range(0, NIN - 1));
      in_valid  = NIN'($urandom_range(0, 7));
      out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NIN; i++) in_word[i] = $urandom;
      settle();
      exp_rdy = (q.size() < 2) ? (NIN'(1) << sel) : '0;
      check("wr_in_ready",  in_ready,  exp_rdy);
      check("wr_out_valid", out_valid, q.size() != 0);
      if (q.size() != 0 && out_ready) begin
        d = q.pop_front();
        check("wr_out_data", out_data, d);
      end
      if (in_valid[sel] && exp_rdy[sel]) begin
        q.push_back(in_word[sel]);
        n_acc++;
      end
      tick();
    end
    check("wr_accepts", n_acc, 17);
    in_valid = '0; out_ready = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 10) begin
      budget++;
      settle();
      check("dr_out_valid", out_valid, 1'b1);
      d = q.pop_front();
      check("dr_out_data", out_data, d);
      tick();
    end
    check("dr_empty_model", q.size(), 0);
    check("dr_empty_dut",   out_valid, 1'b0);
    check("wr_xfer_cnt",    xfer_cnt,  4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
